// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;
    localparam int OP_W = 3;

    // Word-aligning mask for bus addresses.
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Memory-op codes as produced by the decode stage.
    typedef enum logic [OP_W-1:0] {
        MOP_LW  = 3'b000,
        MOP_SW  = 3'b001,
        MOP_LB  = 3'b010,
        MOP_SB  = 3'b011,
        MOP_LBU = 3'b110
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store-side enables/replication from the live request,
// load-side extraction/extension from the latched op and lane.
module mem_lane_fmt
    import mem_arb_pkg::*;
(
    input  logic [OP_W-1:0] st_op,
    input  logic [1:0]      st_lane,
    input  logic [XLEN-1:0] st_wdata,
    output logic            st_we,
    output logic [BE_W-1:0] st_be,
    output logic [XLEN-1:0] st_bus_wdata,
    output logic            op_legal,
    input  logic [OP_W-1:0] ld_op,
    input  logic [1:0]      ld_lane,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0] byte_sel;

    // Store side: illegal ops get no enables so nothing can be written.
    always_comb begin
        st_we        = 1'b0;
        st_be        = '0;
        st_bus_wdata = '0;
        op_legal     = 1'b1;
        case (st_op)
            MOP_LW, MOP_LB, MOP_LBU: st_be = 4'hF;
            MOP_SW: begin
                st_we        = 1'b1;
                st_be        = 4'hF;
                st_bus_wdata = st_wdata;
            end
            MOP_SB: begin
                st_we        = 1'b1;
                st_be        = 4'b0001 << st_lane;
                st_bus_wdata = {4{st_wdata[7:0]}};
            end
            default: op_legal = 1'b0;
        endcase
    end

    // Load side: pick the addressed byte and extend according to the op.
    always_comb begin
        case (ld_lane)
            2'd0:    byte_sel = ld_rdata[7:0];
            2'd1:    byte_sel = ld_rdata[15:8];
            2'd2:    byte_sel = ld_rdata[23:16];
            default: byte_sel = ld_rdata[31:24];
        endcase
        case (ld_op)
            MOP_LW:  ld_data = ld_rdata;
            MOP_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            MOP_LBU: ld_data = {24'h0, byte_sel};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported memory between fetch (IF) and data (MEM).
// One bus transaction at a time: IDLE -> FETCH/DATA -> RESP -> IDLE.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort stalled accesses
// after TIMEOUT_CYCLES and flag them on err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        err
);

    arb_state_e      state_q, state_d;
    logic [2:0]      starve_q, starve_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [1:0]      lane_q, lane_d;
    logic            legal_q, legal_d;
    logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [BE_W-1:0] bus_be_q, bus_be_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic            if_valid_q, if_valid_d, mem_valid_q, mem_valid_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic            bus_done;

    logic            fmt_we, fmt_legal;
    logic [BE_W-1:0] fmt_be;
    logic [XLEN-1:0] fmt_wdata, fmt_ld_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
`endif

    mem_lane_fmt u_fmt (
        .st_op        (mem_op),
        .st_lane      (mem_addr[1:0]),
        .st_wdata     (mem_wdata),
        .st_we        (fmt_we),
        .st_be        (fmt_be),
        .st_bus_wdata (fmt_wdata),
        .op_legal     (fmt_legal),
        .ld_op        (op_q),
        .ld_lane      (lane_q),
        .ld_rdata     (bus_rdata),
        .ld_data      (fmt_ld_data)
    );

    // Next-state: arbitration in IDLE, completion/abort in FETCH/DATA.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        op_d        = op_q;
        lane_d      = lane_q;
        legal_d     = legal_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        bus_done    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_d      = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!if_req) starve_d = '0;
                // IF wins only when MEM is absent or has starved it long enough.
                if (if_req && (!mem_req || starve_q == 3'(STARVE_LIMIT))) begin
                    state_d     = FETCH;
                    starve_d    = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = 4'hF;
                    bus_addr_d  = if_addr & WORD_MASK;
                    bus_wdata_d = '0;
                end else if (mem_req) begin
                    state_d     = DATA;
                    if (if_req && starve_q != 3'd7) starve_d = starve_q + 3'd1;
                    op_d        = mem_op;
                    lane_d      = mem_addr[1:0];
                    legal_d     = fmt_legal;
                    bus_req_d   = fmt_legal;
                    bus_we_d    = fmt_we;
                    bus_be_d    = fmt_be;
                    bus_addr_d  = fmt_legal ? (mem_addr & WORD_MASK) : '0;
                    bus_wdata_d = fmt_wdata;
                end
            end
            FETCH, DATA: begin
                if (state_q == DATA && !legal_q) begin
                    // Illegal op never touched the bus; answer with zero.
                    state_d     = RESP;
                    mem_valid_d = 1'b1;
                    mem_rdata_d = '0;
                end else if (bus_ready) begin
                    state_d  = RESP;
                    bus_done = 1'b1;
                    if (state_q == FETCH) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus_rdata;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = fmt_ld_data;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = RESP;
                    bus_done = 1'b1;
                    err_d    = 1'b1;
                    if (state_q == FETCH) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus_done) begin
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_be_d    = '0;
            bus_addr_d  = '0;
            bus_wdata_d = '0;
        end
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            op_q        <= '0;
            lane_q      <= '0;
            legal_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            legal_q     <= legal_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign stall_f   = if_req & ~if_valid_q;
    assign stall_m   = mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks plus a randomized phase against a word-array reference model.
module tb_mem_port_arbiter;

    localparam logic [2:0] OP_LW = 3'b000, OP_SW = 3'b001, OP_LB = 3'b010;
    localparam logic [2:0] OP_SB = 3'b011, OP_LBU = 3'b110, OP_BAD = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_req, bus_ready;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [2:0]  mem_op;
    logic        if_valid, mem_valid, stall_f, stall_m, bus_req, bus_we, err;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT(4)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One MEM access from IDLE with an always-ready bus; captures bus fields.
    task automatic mem_xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, output logic [31:0] res, output int lat,
                            output logic [31:0] ba, output logic [3:0] be, output logic [31:0] bwd);
        mem_req = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
        bus_ready = 1'b1; bus_rdata = rd;
        lat = 0; ba = 'x; be = 'x; bwd = 'x;
        while (!mem_valid && lat < 20) begin
            tick();
            lat++;
            if (bus_req) begin ba = bus_addr; be = bus_be; bwd = bus_wdata; end
        end
        res = mem_rdata;
        mem_req = 1'b0; bus_ready = 1'b0;
        tick();
    endtask

    logic [31:0] res, ba, bwd, w, expv;
    logic [3:0]  be;
    logic [7:0]  b8;
    int          lat, n, lane, idx, if_age, mem_age, n_if, n_mem, wait_b;
    logic        seen;
    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];
    logic [2:0]  op_pool [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

    initial begin
        rst_n = 1'b0; if_req = 0; mem_req = 0; bus_ready = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_op = 0; bus_rdata = 0;
        tick(); tick();
        check("rst_bus_req", {31'h0, bus_req}, 0);
        check("rst_bus_fields", {bus_we, bus_be, 27'h0}, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_valids", {29'h0, if_valid, mem_valid, err}, 0);
        check("rst_rdata", if_rdata | mem_rdata, 0);
        rst_n = 1'b1;
        tick();

        // IF only, ready on the first bus cycle.
        if_req = 1; if_addr = 32'h100; bus_ready = 1; bus_rdata = 32'h00500093;
        #1 check("if_stall_c0", {31'h0, stall_f}, 1);
        tick();
        check("if_bus_req", {31'h0, bus_req}, 1);
        check("if_bus_addr", bus_addr, 32'h100);
        check("if_bus_be_we", {27'h0, bus_we, bus_be}, 32'h0F);
        check("if_stall_c1", {30'h0, stall_f, if_valid}, 2);
        tick();
        check("if_valid", {31'h0, if_valid}, 1);
        check("if_rdata", if_rdata, 32'h00500093);
        check("if_stall_drop", {30'h0, stall_f, bus_req}, 0);
        if_req = 0; bus_ready = 0;
        tick();
        check("if_valid_pulse", {31'h0, if_valid}, 0);

        // Both requesting: MEM first, IF after STARVE_LIMIT MEM grants, then MEM again.
        if_req = 1; if_addr = 32'h100; mem_req = 1; mem_op = OP_LW; mem_addr = 32'h200;
        bus_ready = 1; bus_rdata = 32'h12345678;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (!bus_req && n < 10) begin tick(); n++; end
            check($sformatf("grant_%0d_is_if", g), {31'h0, bus_addr != 32'h200}, (g == 4) ? 1 : 0);
            tick();
            if (g == 0) begin
                check("lw_valid", {31'h0, mem_valid}, 1);
                check("lw_rdata", mem_rdata, 32'h12345678);
            end
        end
        if_req = 0; mem_req = 0; bus_ready = 0;
        tick(); tick();

        // SB lane replication and stable bus while waiting.
        mem_req = 1; mem_op = OP_SB; mem_addr = 32'h203; mem_wdata = 32'hAB; bus_ready = 0;
        tick();
        check("sb_bus", {27'h0, bus_req, bus_we, bus_be}, {27'h0, 2'b11, 4'b1000});
        check("sb_wdata", bus_wdata, 32'hABABABAB);
        check("sb_addr", bus_addr, 32'h200);
        #1 check("sb_stall_m", {31'h0, stall_m}, 1);
        tick();
        check("sb_hold_be", {28'h0, bus_be}, 4'b1000);
        bus_ready = 1;
        tick();
        check("sb_valid", {31'h0, mem_valid}, 1);
        mem_req = 0; bus_ready = 0;
        tick();

        // Byte loads, misaligned word access.
        mem_xact(OP_LB, 32'h201, 0, 32'h00008000, res, lat, ba, be, bwd);
        check("lb_data", res, 32'hFFFFFF80);
        check("lb_lat", lat, 2);
        check("lb_addr", ba, 32'h200);
        mem_xact(OP_LBU, 32'h201, 0, 32'h00008000, res, lat, ba, be, bwd);
        check("lbu_data", res, 32'h00000080);
        mem_xact(OP_LW, 32'h203, 0, 32'hCAFEBABE, res, lat, ba, be, bwd);
        check("lw_mis_addr", ba, 32'h200);
        check("lw_mis_data", res, 32'hCAFEBABE);
        mem_xact(OP_SW, 32'h206, 32'h11223344, 0, res, lat, ba, be, bwd);
        check("sw_addr", ba, 32'h204);
        check("sw_be", {28'h0, be}, 4'hF);
        check("sw_wdata", bwd, 32'h11223344);

        // Illegal op: no bus access, zero data, same latency.
        mem_req = 1; mem_op = OP_BAD; mem_addr = 32'h208; bus_ready = 0; bus_rdata = '1;
        tick();
        check("bad_no_bus", {30'h0, bus_req, bus_we}, 0);
        tick();
        check("bad_valid", {31'h0, mem_valid}, 1);
        check("bad_rdata", mem_rdata, 0);
        mem_req = 0;
        tick();

        // Reset during DATA abandons the access.
        mem_req = 1; mem_op = OP_LW; mem_addr = 32'h204; bus_ready = 0;
        tick();
        check("rstm_busy", {31'h0, bus_req}, 1);
        rst_n = 0;
        tick();
        check("rstm_drop", {30'h0, bus_req, mem_valid}, 0);
        rst_n = 1; mem_req = 0;
        tick();
        check("rstm_after", {30'h0, bus_req, mem_valid}, 0);
        if_req = 1; if_addr = 32'h104; bus_ready = 1; bus_rdata = 32'h00A00113;
        tick(); tick();
        check("rstm_idle_if", {31'h0, if_valid}, 1);
        check("rstm_idle_data", if_rdata, 32'h00A00113);
        if_req = 0; bus_ready = 0;
        tick();

        // Bus never ready.
        mem_req = 1; mem_op = OP_LW; mem_addr = 32'h20C; bus_ready = 0; bus_rdata = 32'h55AA55AA;
`ifdef MEM_ARB_TIMEOUT_EN
        n = 0;
        while (!mem_valid && n < 40) begin tick(); n++; end
        check("tmo_lat", n, 9);
        check("tmo_err", {31'h0, err}, 1);
        check("tmo_rdata", mem_rdata, 0);
        check("tmo_bus_drop", {31'h0, bus_req}, 0);
        mem_req = 0;
        tick();
        check("tmo_err_pulse", {31'h0, err}, 0);
`else
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (mem_valid) seen = 1;
        end
        check("wait_hold", {30'h0, bus_req, seen}, 2);
        bus_ready = 1;
        tick();
        check("wait_done", {30'h0, mem_valid, err}, 2);
        mem_req = 0; bus_ready = 0;
        tick();
`endif

        // Randomized traffic against a word-array reference model.
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        if_req = 0; mem_req = 0; bus_ready = 0;
        if_age = 0; mem_age = 0; n_if = 0; n_mem = 0; wait_b = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (if_valid) begin
                check("rnd_if", if_rdata, ref_mem[if_addr[9:2]]);
                n_if++;
                if_req = 0;
            end
            if (mem_valid) begin
                idx = int'(mem_addr[9:2]);
                lane = int'(mem_addr[1:0]);
                w = ref_mem[idx];
                b8 = 8'((w >> (8 * lane)) & 32'hFF);
                expv = 0;
                case (mem_op)
                    OP_LW:  expv = w;
                    OP_LB:  expv = {{24{b8[7]}}, b8};
                    OP_LBU: expv = {24'h0, b8};
                    OP_SW:  ref_mem[idx] = mem_wdata;
                    OP_SB:  ref_mem[idx][8*lane +: 8] = mem_wdata[7:0];
                    default: expv = 0;
                endcase
                if (mem_op != OP_SW && mem_op != OP_SB)
                    check($sformatf("rnd_mem_op%0d", mem_op), mem_rdata, expv);
                check("rnd_err", {31'h0, err}, 0);
                n_mem++;
                mem_req = 0;
            end
            if_age  = if_req ? if_age + 1 : 0;
            mem_age = mem_req ? mem_age + 1 : 0;
            if (if_age > 200 || mem_age > 200) break;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
            end
            if (!mem_req && $urandom_range(0, 1) == 0) begin
                mem_req = 1;
                mem_op = op_pool[$urandom_range(0, 5)];
                mem_addr = 32'h200 + 32'($urandom_range(0, 63));
                mem_wdata = $urandom;
            end
            if (bus_req) begin
                if (wait_b >= 3 || $urandom_range(0, 2) != 0) begin
                    bus_ready = 1;
                    bus_rdata = bus_mem[bus_addr[9:2]];
                    if (bus_we)
                        for (int b = 0; b < 4; b++)
                            if (bus_be[b]) bus_mem[bus_addr[9:2]][8*b +: 8] = bus_wdata[8*b +: 8];
                    wait_b = 0;
                end else begin
                    bus_ready = 0; bus_rdata = $urandom; wait_b++;
                end
            end else begin
                bus_ready = 0; bus_rdata = $urandom; wait_b = 0;
            end
            tick();
        end
        check("rnd_hang", {31'h0, (if_age > 200 || mem_age > 200)}, 0);
        check("rnd_progress", {30'h0, n_if > 50, n_mem > 50}, 3);
        for (int i = 128; i < 144; i++)
            check($sformatf("rnd_mem_word_%0d", i), bus_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified memory between the pipeline's fetch stage (IF) and memory stage (MEM). It sequences one bus transaction at a time, formats byte lanes for the LW/LB/LBU/SW/SB memory-op codes that the decode stage produces, and drives the fetch and memory stall signals into the pipeline. It sits between the IF/MEM stages and the memory bus.

## Interface
- One clock; reset is synchronous and active-low.
- STARVE_LIMIT, 4: consecutive MEM grants allowed while `if_req` is pending before IF is forced a grant.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles. Used only with `MEM_ARB_TIMEOUT_EN`.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request. Level signal, held until `if_valid`.
- if_addr  in  32  fetch byte address; word-aligned
- if_valid  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched instruction; valid with `if_valid`
- mem_req  in  1  data request. Level signal, held until `mem_valid`.
- mem_op  in  3  000 LW, 001 SW, 010 LB, 011 SB, 110 LBU
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data; byte in [7:0] for SB
- mem_valid  out  1  one-cycle data completion pulse
- mem_rdata  out  32  formatted load data; valid with `mem_valid`
- stall_f  out  1  `if_req & ~if_valid`
- stall_m  out  1  `mem_req & ~mem_valid`
- bus_req  out  1  registered bus request
- bus_we  out  1  write strobe
- bus_be  out  4  byte enables
- bus_addr  out  32  word address; bits [1:0] forced to 0
- bus_wdata  out  32  lane-replicated write data
- bus_ready  in  1  bus completes the access in this cycle
- bus_rdata  in  32  read word; valid when `bus_ready` is high
- err  out  1  timeout pulse; coincides with the valid pulse

## Operation
- FSM states:
  - IDLE → FETCH on an IF grant.
  - IDLE → DATA on a MEM grant.
  - FETCH/DATA → RESP when `bus_ready` is sampled high.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE:
  - If only one side requests, that side is granted.
  - If both request, MEM wins. Exception: `starve_cnt == STARVE_LIMIT` grants IF instead.
- starve_cnt (3 bits, saturating):
  - +1 on each MEM grant while `if_req` is high.
  - Cleared on an IF grant, or when `if_req` is low in IDLE.
- No request is accepted in RESP. A requester that sees valid presents its next request in the following cycle.
- Requests and operand changes are sampled only in IDLE. The address and op are latched at the grant.
- Byte lanes for LB/LBU/SB are selected by `addr[1:0]`:
  - SB: `bus_be = 1 << addr[1:0]`, `bus_wdata = {4{wdata[7:0]}}`.
  - SW: `bus_be = 4'hF`.
  - LW/LB/LBU: `bus_we = 0`, `bus_be = 4'hF`.
  - LB: selected byte is sign-extended.
  - LBU: selected byte is zero-extended.
  - LW: word is passed through unchanged.
- Illegal `mem_op`: no bus access. DATA → RESP in the next cycle, `mem_rdata = 0`, nothing written.
- Misaligned LW/SW: the address is truncated to the word; no trap.

## Timing
- Grant at edge t. `bus_*` outputs are valid from cycle t+1 and held stable until `bus_ready`.
- If `bus_ready` is high in cycle k, the RESP valid pulse and registered rdata appear in cycle k+1. IDLE is reached at k+2.
- Minimum latency: request seen in cycle t → valid in t+2. Peak throughput is one access per 3 cycles.
- Reset values: state IDLE, `starve_cnt = 0`, all `bus_*` = 0, `if_valid = mem_valid = err = 0`, `if_rdata = mem_rdata = 0`.
- Reset mid-transaction: the next cycle shows `bus_req = 0`, state IDLE, and no valid pulse. The in-flight access is abandoned.
- `stall_f`/`stall_m` are combinational. They drop in the valid cycle so the stage advances on that edge.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A wait counter runs in FETCH/DATA.
  - At TIMEOUT_CYCLES without `bus_ready`, the arbiter drops `bus_req` and enters RESP.
  - In RESP it outputs rdata 0 with `err = 1` alongside valid.
- Undefined: the arbiter waits indefinitely. The `err` port remains present, tied to 0.

## Structure
- Package `mem_arb_pkg`:
  - `mem_op_e` enum with MOP_LW/SW/LB/SB/LBU, matching the decode-stage MemWrite encoding.
  - `arb_state_e` (IDLE/FETCH/DATA/RESP).
  - Width constants.
- Sub-module `mem_lane_fmt`: combinational. Computes `bus_be`/`bus_wdata` from op, address and data, and load formatting from op, `addr[1:0]` and `bus_rdata`.

## Test plan
- IF only, `if_addr = 0x100`, `bus_ready` high on first cycle, `bus_rdata = 0x00500093` → `if_valid` 2 cycles after request, `if_rdata = 0x00500093`, `stall_f` high for 2 cycles.
- Simultaneous IF+MEM LW at `0x200` → DATA granted first, then IF. With MEM held requesting, IF is granted after 4 consecutive MEM grants.
- SB `addr = 0x203`, `wdata = 0x000000AB` → `bus_be = 4'b1000`, `bus_wdata = 0xABABABAB`, `bus_we = 1`.
- LB/LBU `addr = 0x201`, `bus_rdata = 0x00008000` → LB returns 0xFFFFFF80, LBU returns 0x00000080.
- `rst_n` low while in DATA with `bus_ready` low → `bus_req = 0` next cycle, no `mem_valid`, IDLE afterwards.
- With `MEM_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES = 8, `bus_ready` held low → `mem_valid` and `err` pulse together, `mem_rdata = 0`. Without the macro, the arbiter is still waiting after 100 cycles.
